// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing scheduler.
// Holds the ID-width derivation and the in-flight tag layout.
package mult_share_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int A_WIDTH_DEF  = 16;
  localparam int B_WIDTH_DEF  = 16;
  localparam int MULT_LAT_DEF = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int ID_W_DEF = clog2(N_REQ_DEF);

  typedef struct packed {
    logic                valid;
    logic [ID_W_DEF-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping.
// Purely combinational; one-hot grant plus binary grant index.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one pipelined multiplier between N_REQ requesters.
// Registers granted operands and returns results tagged by requester.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int A_WIDTH  = A_WIDTH_DEF,
  parameter int B_WIDTH  = B_WIDTH_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int ID_W     = clog2(N_REQ)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*A_WIDTH-1:0]   req_a,
  input  logic [N_REQ*B_WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]           req_tc,
  output logic [A_WIDTH-1:0]         mult_a,
  output logic [B_WIDTH-1:0]         mult_b,
  output logic                       mult_tc,
  input  logic [A_WIDTH+B_WIDTH-1:0] mult_product,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [A_WIDTH+B_WIDTH-1:0] rsp_product,
  output logic                       busy
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } ptag_t;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic             fire;
  ptag_t            tag_q [MULT_LAT+1];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // No grants while reset is held, even with requests pending.
  assign req_ready = RST_N ? gnt : '0;
  assign fire      = |(req_valid & req_ready);

  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      if (gnt_id == ID_W'(N_REQ - 1)) ptr_d = '0;
      else                            ptr_d = gnt_id + ID_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mult_a  <= '0;
      mult_b  <= '0;
      mult_tc <= 1'b0;
    end else if (fire) begin
      mult_a  <= req_a[gnt_id*A_WIDTH +: A_WIDTH];
      mult_b  <= req_b[gnt_id*B_WIDTH +: B_WIDTH];
      mult_tc <= req_tc[gnt_id];
    end
  end

  // Tag pipe tracks the multiplier latency, never stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i <= MULT_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: fire, id: gnt_id};
      for (int i = 1; i <= MULT_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= MULT_LAT; i++) busy = busy | tag_q[i].valid;
  end

  assign rsp_valid   = tag_q[MULT_LAT].valid;
  assign rsp_id      = tag_q[MULT_LAT].id;
  assign rsp_product = mult_product;

endmodule

// File: tb/tb_mult_share_sched.sv
// Randomized self-checking bench for mult_share_sched.
// Scoreboard of expected responses keyed by due cycle.
module tb_mult_share_sched;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int PW = AW + BW;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]  req_tc;
  logic [AW-1:0] mult_a;
  logic [BW-1:0] mult_b;
  logic          mult_tc;
  logic [PW-1:0] mult_product;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [PW-1:0] rsp_product;
  logic          busy;

  always #5 CLK = ~CLK;

  mult_share_sched dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tc       (req_tc),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_tc      (mult_tc),
    .mult_product (mult_product),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_product  (rsp_product),
    .busy         (busy)
  );

  // Behavioural stand-in for the 2-stage multiplier (one register).
  logic signed [PW+1:0] sprod;
  logic [PW-1:0]        uprod;
  assign sprod = $signed({mult_a[AW-1], mult_a}) * $signed({mult_b[BW-1], mult_b});
  assign uprod = mult_a * mult_b;
  always @(posedge CLK) mult_product <= mult_tc ? sprod[PW-1:0] : uprod;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [PW-1:0] prod;
  } exp_t;

  exp_t q[$];
  int   mptr;
  int   cyc;
  int   nchk;
  int   nfail;

  function automatic logic [PW-1:0] ref_mul(input logic [AW-1:0] a,
                                            input logic [BW-1:0] b,
                                            input logic tc);
    longint p;
    if (tc) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'(a) * longint'(b);
    return p[PW-1:0];
  endfunction

  // Drives one cycle and advances the reference model.
  task automatic drive_cycle(input logic [N-1:0] v,
                             input logic [N*AW-1:0] a,
                             input logic [N*BW-1:0] b,
                             input logic [N-1:0] tc,
                             output logic [N-1:0] eg,
                             output logic erv,
                             output logic [1:0] eid,
                             output logic [PW-1:0] ep,
                             output logic eb);
    exp_t e;
    bit   got;
    @(negedge CLK);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_tc    = tc;
    #1;
    eb  = (q.size() > 0);
    erv = 1'b0;
    eid = '0;
    ep  = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e   = q.pop_front();
      erv = 1'b1;
      eid = e.id;
      ep  = e.prod;
    end
    eg  = '0;
    got = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (!got && v[i]) begin
        got   = 1;
        eg[i] = 1'b1;
        e.due = cyc + 2;
        e.id  = 2'(i);
        e.prod = ref_mul(a[i*AW +: AW], b[i*BW +: BW], tc[i]);
        q.push_back(e);
        mptr = (i + 1) % N;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    RST_N     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_tc    = '0;
    repeat (2) @(negedge CLK);
    #1;
    nchk++;
    if (req_ready !== 4'b0000) begin
      nfail++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    nchk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_rsp got=%b/%b exp=0/0", rsp_valid, busy);
    end
    nchk++;
    if (mult_a !== '0 || mult_b !== '0 || mult_tc !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mult got=%h/%h/%b exp=0", mult_a, mult_b, mult_tc);
    end
    req_valid = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    q.delete();
    mptr = 0;
    cyc  = 0;
  endtask

  task automatic test_single();
    logic [N-1:0] eg;
    logic erv, eb;
    logic [1:0] eid;
    logic [PW-1:0] ep;
    logic [N*AW-1:0] a;
    logic [N*BW-1:0] b;
    a = '0;
    b = '0;
    a[0 +: AW] = 16'd3;
    b[0 +: BW] = 16'hFFFE;
    for (int c = 0; c < 6; c++) begin
      drive_cycle((c == 2) ? 4'b0001 : 4'b0000, a, b, 4'b0001,
                  eg, erv, eid, ep, eb);
      nchk++;
      if (req_ready !== eg) begin
        nfail++;
        $display("FAIL single_ready cyc=%0d got=%b exp=%b", cyc, req_ready, eg);
      end
      nchk++;
      if (rsp_valid !== erv) begin
        nfail++;
        $display("FAIL single_rv cyc=%0d got=%b exp=%b", cyc, rsp_valid, erv);
      end
      if (erv) begin
        nchk++;
        if (rsp_id !== eid || rsp_product !== 32'hFFFF_FFFA) begin
          nfail++;
          $display("FAIL single_rsp got=%0d/%h exp=%0d/fffffffa", rsp_id, rsp_product, eid);
        end
      end
      nchk++;
      if (busy !== eb) begin
        nfail++;
        $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
      end
    end
  endtask

  task automatic test_pattern(input string name, input logic [N-1:0] v,
                              input int hold, input logic [N-1:0] tc,
                              input bit max_ops);
    logic [N-1:0] eg;
    logic erv, eb;
    logic [1:0] eid;
    logic [PW-1:0] ep;
    logic [N*AW-1:0] a;
    logic [N*BW-1:0] b;
    for (int c = 0; c < hold + 3; c++) begin
      for (int i = 0; i < N; i++) begin
        a[i*AW +: AW] = max_ops ? 16'hFFFF : 16'($urandom);
        b[i*BW +: BW] = max_ops ? 16'hFFFF : 16'($urandom);
      end
      drive_cycle((c < hold) ? v : 4'b0000, a, b, tc, eg, erv, eid, ep, eb);
      nchk++;
      if (req_ready !== eg) begin
        nfail++;
        $display("FAIL %s_ready cyc=%0d got=%b exp=%b", name, cyc, req_ready, eg);
      end
      nchk++;
      if (rsp_valid !== erv) begin
        nfail++;
        $display("FAIL %s_rv cyc=%0d got=%b exp=%b", name, cyc, rsp_valid, erv);
      end
      if (erv) begin
        nchk++;
        if (rsp_id !== eid || rsp_product !== ep) begin
          nfail++;
          $display("FAIL %s_rsp cyc=%0d got=%0d/%h exp=%0d/%h",
                   name, cyc, rsp_id, rsp_product, eid, ep);
        end
      end
      nchk++;
      if (busy !== eb) begin
        nfail++;
        $display("FAIL %s_busy cyc=%0d got=%b exp=%b", name, cyc, busy, eb);
      end
    end
  endtask

  task automatic test_unsigned();
    test_pattern("unsigned", 4'b0100, 1, 4'b0000, 1'b1);
    nchk++;
    if (mult_a !== 16'hFFFF || mult_tc !== 1'b0) begin
      nfail++;
      $display("FAIL unsigned_ops got=%h/%b exp=ffff/0", mult_a, mult_tc);
    end
  endtask

  task automatic test_midop_reset();
    logic [N-1:0] eg;
    logic erv, eb;
    logic [1:0] eid;
    logic [PW-1:0] ep;
    for (int c = 0; c < 2; c++) begin
      drive_cycle(4'b1111, {4{16'h0101}}, {4{16'h0202}}, 4'b0000,
                  eg, erv, eid, ep, eb);
      nchk++;
      if (req_ready !== eg) begin
        nfail++;
        $display("FAIL midrst_ready cyc=%0d got=%b exp=%b", cyc, req_ready, eg);
      end
    end
    #2;
    RST_N = 1'b0;
    #1;
    nchk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      nfail++;
      $display("FAIL midrst_clear got=%b/%b/%b exp=0/0/0000", busy, rsp_valid, req_ready);
    end
    req_valid = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    q.delete();
    mptr = 0;
    test_pattern("postrst_idle", 4'b0000, 2, 4'b0000, 1'b0);
    test_pattern("postrst_grant", 4'b1111, 1, 4'b1111, 1'b0);
  endtask

  task automatic test_random(input int ncyc);
    logic [N-1:0] eg;
    logic erv, eb;
    logic [1:0] eid;
    logic [PW-1:0] ep;
    logic [N-1:0] v;
    logic [N*AW-1:0] a;
    logic [N*BW-1:0] b;
    logic [N-1:0] tc;
    v = '0;
    a = '0;
    b = '0;
    tc = '0;
    for (int c = 0; c < ncyc + 3; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c < ncyc && !v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          a[i*AW +: AW] = 16'($urandom);
          b[i*BW +: BW] = 16'($urandom);
          tc[i] = 1'($urandom);
        end
      end
      drive_cycle(v, a, b, tc, eg, erv, eid, ep, eb);
      v = v & ~eg;
      nchk++;
      if (req_ready !== eg) begin
        nfail++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, eg);
      end
      nchk++;
      if (rsp_valid !== erv) begin
        nfail++;
        $display("FAIL rand_rv cyc=%0d got=%b exp=%b", cyc, rsp_valid, erv);
      end
      if (erv) begin
        nchk++;
        if (rsp_id !== eid || rsp_product !== ep) begin
          nfail++;
          $display("FAIL rand_rsp cyc=%0d got=%0d/%h exp=%0d/%h",
                   cyc, rsp_id, rsp_product, eid, ep);
        end
      end
      nchk++;
      if (busy !== eb) begin
        nfail++;
        $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
      end
    end
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    mptr  = 0;
    cyc   = 0;
    test_reset();
    test_single();
    test_pattern("round_robin", 4'b1111, 8, 4'b1010, 1'b0);
    test_pattern("set_ptr2", 4'b0010, 1, 4'b0000, 1'b0);
    test_pattern("skip_wrap", 4'b0011, 3, 4'b0011, 1'b0);
    test_unsigned();
    test_pattern("lone_req", 4'b1000, 4, 4'b1000, 1'b0);
    test_midop_reset();
    test_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
